// File: rtl/alu_wb_mux_pipe.sv
// -----------------------------------------------------------------------------
// alu_wb_mux_pipe
//
// Registered N-way writeback source selector with a valid/ready handshake and a
// one-entry skid buffer. One of NUM_IN channels (0 = ALU result, 1 = bus, the
// rest design-defined) is selected by sel when a word is accepted, tagged with
// a zero flag and an out-of-range-select error flag, and presented on the
// writeback side. The skid entry lets the sink stall for a cycle without the
// source losing a word, and it keeps in_ready a pure register output.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_data    NUM_IN packed channels, channel k = in_data[k*WIDTH +: WIDTH]
//   sel        channel select, sampled together with in_valid
//   in_valid   source presents data/sel
//   in_ready   block can accept this cycle (registered, = !skid_valid)
//   out_data   selected, registered word
//   out_zero   out_data == 0, travels with the word
//   out_err    word was produced from an out-of-range sel
//   out_valid  out_data/out_zero/out_err are valid
//   out_ready  sink consumes the word this cycle
// -----------------------------------------------------------------------------
module alu_wb_mux_pipe #(
  parameter int WIDTH  = 24,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_zero,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Elaboration-time sanity check of the parameter set.
  if (NUM_IN < 2 || (2 ** SEL_W) < NUM_IN) begin : g_param_check
    $error("alu_wb_mux_pipe: need NUM_IN >= 2 and 2**SEL_W >= NUM_IN");
  end

  // The state encoding is literally {out_valid, skid_valid}, so both flags are
  // plain bits of the state register and need no extra decode.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             err;
  } word_t;

  state_t state;
  state_t state_nxt;

  word_t  cap_word;   // word that an accept this cycle would capture
  word_t  out_word;   // output register
  word_t  skid_word;  // skid register, holds the second (younger) word

  logic   skid_valid;
  logic   accept;
  logic   consume;
  logic   load_out;
  logic   out_from_skid;
  logic   load_skid;

  assign out_valid  = state[1];
  assign skid_valid = state[0];
  assign in_ready   = !skid_valid;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Channel select. A compare loop is used instead of a variable part-select so
  // that an out-of-range sel never indexes past the packed input vector; with
  // no match the word stays zero and err stays set.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cap_word     = '0;
    cap_word.err = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        cap_word.data = in_data[k*WIDTH +: WIDTH];
        cap_word.err  = 1'b0;
      end
    end
    cap_word.zero = (cap_word.data == '0);
  end

  // ---------------------------------------------------------------------------
  // Next-state and register-load decode.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    load_out      = 1'b0;
    out_from_skid = 1'b0;
    load_skid     = 1'b0;

    unique case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_ONE;
          load_out  = 1'b1;
        end
      end

      ST_ONE: begin
        if (accept && !consume) begin
          // Sink is stalling: park the new word behind the current one.
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (accept && consume) begin
          // Pass-through at full rate: new word replaces the consumed one.
          load_out = 1'b1;
        end else if (consume) begin
          state_nxt = ST_EMPTY;
        end
      end

      ST_FULL: begin
        // in_ready is low here, so only the sink can make progress.
        if (consume) begin
          state_nxt     = ST_ONE;
          load_out      = 1'b1;
          out_from_skid = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and data registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state     <= ST_EMPTY;
      // NOTE: the data registers are reset too (not just the valid bits) so the
      // outputs read as zero after reset; with only two words of storage this
      // is cheap, unlike clearing a real memory array.
      out_word  <= '0;
      skid_word <= '0;
    end else begin
      state <= state_nxt;
      if (load_out) begin
        out_word <= out_from_skid ? skid_word : cap_word;
      end
      if (load_skid) begin
        skid_word <= cap_word;
      end
    end
  end

  assign out_data = out_word.data;
  assign out_zero = out_word.zero;
  assign out_err  = out_word.err;

endmodule

// File: tb/tb_alu_wb_mux_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_wb_mux_pipe
//
// Three instances of the writeback selector share clock and reset:
//   a: WIDTH=24, NUM_IN=4, SEL_W=2  directed pass-through, stall, zero, reset
//   b: WIDTH=24, NUM_IN=3, SEL_W=2  out-of-range select
//   c: WIDTH=32, NUM_IN=8, SEL_W=3  random valid/ready sweep
// Drivers set inputs plus the word they expect that input to produce. A
// monitor on the falling edge records accepts into a per-instance queue,
// compares every presented output against the queue head, pops on consume, and
// checks in_ready/out_valid against the queue occupancy.
// -----------------------------------------------------------------------------
module tb_alu_wb_mux_pipe;

  typedef struct packed {
    logic [31:0] data;
    logic        zero;
    logic        err;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance a
  logic [95:0]  a_in_data = '0;
  logic [1:0]   a_sel = '0;
  logic         a_in_valid = 1'b0, a_out_ready = 1'b1;
  logic         a_in_ready, a_out_zero, a_out_err, a_out_valid;
  logic [23:0]  a_out_data;
  word_t        a_exp = '0;

  // instance b
  logic [71:0]  b_in_data = '0;
  logic [1:0]   b_sel = '0;
  logic         b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic         b_in_ready, b_out_zero, b_out_err, b_out_valid;
  logic [23:0]  b_out_data;
  word_t        b_exp = '0;

  // instance c
  logic [255:0] c_in_data = '0;
  logic [2:0]   c_sel = '0;
  logic         c_in_valid = 1'b0, c_out_ready = 1'b1;
  logic         c_in_ready, c_out_zero, c_out_err, c_out_valid;
  logic [31:0]  c_out_data;
  word_t        c_exp = '0;

  alu_wb_mux_pipe #(.WIDTH(24), .NUM_IN(4), .SEL_W(2)) u_dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .sel(a_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_zero(a_out_zero), .out_err(a_out_err), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
  );

  alu_wb_mux_pipe #(.WIDTH(24), .NUM_IN(3), .SEL_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .sel(b_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_zero(b_out_zero), .out_err(b_out_err), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  alu_wb_mux_pipe #(.WIDTH(32), .NUM_IN(8), .SEL_W(3)) u_dut_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .sel(c_sel),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
    .out_zero(c_out_zero), .out_err(c_out_err), .out_valid(c_out_valid),
    .out_ready(c_out_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  function automatic word_t mk(input logic [31:0] d, input logic z,
                               input logic e);
    word_t w;
    w.data = d;
    w.zero = z;
    w.err  = e;
    return w;
  endfunction

  function automatic word_t model_c(input logic [255:0] d, input logic [2:0] s);
    logic [31:0] v;
    v = d[int'(s)*32 +: 32];
    return mk(v, v == 32'd0, 1'b0);
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard queues (words currently held inside each instance).
  // ---------------------------------------------------------------------------
  word_t q0[$];
  word_t q1[$];
  word_t q2[$];

  function automatic int q_size(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic word_t q_front(input int d);
    case (d)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic q_pop(input int d);
    case (d)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic q_push(input int d, input word_t w);
    case (d)
      0:       q0.push_back(w);
      1:       q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  task automatic q_clear(input int d);
    case (d)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Called on each falling edge; everything sampled here is what the next
  // rising edge will act on.
  task automatic observe(input int d, input string nm, input logic iv,
                         input logic ir, input logic ov, input logic ordy,
                         input logic [31:0] od, input logic oz, input logic oe,
                         input word_t nxt);
    int sz;
    if (rst) begin
      q_clear(d);
      return;
    end
    sz = q_size(d);
    check({nm, " in_ready"}, 64'(ir), 64'(sz < 2));
    check({nm, " out_valid"}, 64'(ov), 64'(sz > 0));
    if (ov && sz > 0) begin
      check({nm, " out word {data,zero,err}"}, 64'({od, oz, oe}),
            64'(q_front(d)));
      if (ordy) q_pop(d);
    end
    if (iv && ir) q_push(d, nxt);
  endtask

  always @(negedge clk) begin
    observe(0, "a", a_in_valid, a_in_ready, a_out_valid, a_out_ready,
            32'(a_out_data), a_out_zero, a_out_err, a_exp);
    observe(1, "b", b_in_valid, b_in_ready, b_out_valid, b_out_ready,
            32'(b_out_data), b_out_zero, b_out_err, b_exp);
    observe(2, "c", c_in_valid, c_in_ready, c_out_valid, c_out_ready,
            c_out_data, c_out_zero, c_out_err, c_exp);
  end

  // ---------------------------------------------------------------------------
  // Drivers. Each send holds in_valid until the word is taken (bounded).
  // ---------------------------------------------------------------------------
  task automatic send_a(input logic [1:0] s, input word_t e);
    logic ok;
    a_sel      = s;
    a_exp      = e;
    a_in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = a_in_ready;
      if (!ok) @(posedge clk);
    end
    if (!ok) check("a accept timeout", 64'(ok), 64'(1));
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] s, input word_t e);
    logic ok;
    b_sel      = s;
    b_exp      = e;
    b_in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = b_in_ready;
      if (!ok) @(posedge clk);
    end
    if (!ok) check("b accept timeout", 64'(ok), 64'(1));
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // channel 3 .. channel 0 of instance a
    a_in_data = {24'h123456, 24'd7, 24'd256, 24'd64};
    // channel 2 .. channel 0 of instance b
    b_in_data = {24'hABCDEF, 24'h000111, 24'h00F00D};

    idle(3);
    rst = 1'b0;

    // Reset state, sampled mid-cycle.
    @(negedge clk);
    check("reset a out_valid", 64'(a_out_valid), 64'(0));
    check("reset a in_ready",  64'(a_in_ready),  64'(1));
    check("reset a out_data",  64'(a_out_data),  64'(0));
    check("reset a out_zero",  64'(a_out_zero),  64'(0));
    check("reset a out_err",   64'(a_out_err),   64'(0));
    check("reset c out_valid", 64'(c_out_valid), 64'(0));
    @(posedge clk);
    #1;

    // Back-to-back pass-through, out_ready=1.
    send_a(2'd0, mk(32'd64, 1'b0, 1'b0));
    send_a(2'd1, mk(32'd256, 1'b0, 1'b0));
    idle(3);

    // Stall: fill to FULL, then a third word waits until the sink drains.
    a_out_ready = 1'b0;
    send_a(2'd0, mk(32'd64, 1'b0, 1'b0));
    send_a(2'd1, mk(32'd256, 1'b0, 1'b0));
    fork
      send_a(2'd2, mk(32'd7, 1'b0, 1'b0));
      begin
        idle(4);
        a_out_ready = 1'b1;
      end
    join
    idle(4);

    // Zero detect on a live channel.
    a_in_data[24 +: 24] = 24'd0;
    send_a(2'd1, mk(32'd0, 1'b1, 1'b0));
    send_a(2'd3, mk(32'h123456, 1'b0, 1'b0));
    idle(3);
    a_in_data[24 +: 24] = 24'd256;

    // Out-of-range select on a 3-channel instance.
    send_b(2'd3, mk(32'd0, 1'b1, 1'b1));
    send_b(2'd2, mk(32'hABCDEF, 1'b0, 1'b0));
    send_b(2'd0, mk(32'h00F00D, 1'b0, 1'b0));
    idle(3);

    // Reset from FULL: both held words must vanish.
    a_out_ready = 1'b0;
    send_a(2'd0, mk(32'd64, 1'b0, 1'b0));
    send_a(2'd1, mk(32'd256, 1'b0, 1'b0));
    idle(1);
    check("pre-reset a in_ready (FULL)", 64'(a_in_ready), 64'(0));
    a_out_ready = 1'b1;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset a out_valid", 64'(a_out_valid), 64'(0));
    check("post-reset a out_data",  64'(a_out_data),  64'(0));
    check("post-reset a in_ready",  64'(a_in_ready),  64'(1));
    @(posedge clk);
    #1;
    idle(5);

    // Random sweep on the 8-channel, 32-bit instance.
    for (int cyc = 0; cyc < 1000; cyc++) begin
      for (int k = 0; k < 8; k++) begin
        c_in_data[k*32 +: 32] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
      end
      c_sel       = 3'($urandom_range(0, 7));
      c_in_valid  = ($urandom_range(0, 9) < 6);
      c_out_ready = ($urandom_range(0, 9) < ((cyc / 200) % 2 == 0 ? 4 : 8));
      c_exp       = model_c(c_in_data, c_sel);
      idle(1);
    end
    c_in_valid  = 1'b0;
    c_out_ready = 1'b1;
    idle(5);

    check("a scoreboard drained", 64'(q0.size()), 64'(0));
    check("b scoreboard drained", 64'(q1.size()), 64'(0));
    check("c scoreboard drained", 64'(q2.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_wb_mux_pipe.md
Name: alu_wb_mux_pipe

Overview:
- Parametrised, registered N-way source selector for the datapath writeback path.
- Generalises the 2-input ALU/bus output mux to NUM_IN channels of WIDTH bits.
- Adds a valid/ready handshake and a 1-entry skid buffer so the register-file/bus side can stall the ALU side without data loss.
- Sits between the ALU/bus/immediate/memory sources and the writeback bus.

Parameters:
- WIDTH, 24: data width of every channel and of the output.
- NUM_IN, 4: number of input channels (≥2). Channel 0 = ALU result, channel 1 = bus; the rest are design-defined.
- SEL_W, 2: select width. Must satisfy 2^SEL_W ≥ NUM_IN.

Ports:
- clk  input  1: rising-edge clock.
- rst  input  1: synchronous active-high reset.
- in_data  input  NUM_IN*WIDTH: packed channels. Channel k is in_data[k*WIDTH +: WIDTH].
- sel  input  SEL_W: channel select, sampled with in_valid.
- in_valid  input  1: source presents data/sel.
- in_ready  output  1: block can accept this cycle.
- out_data  output  WIDTH: selected, registered word.
- out_zero  output  1: out_data == 0, travels with the word.
- out_err  output  1: word was produced from an out-of-range sel.
- out_valid  output  1: out_data/out_zero/out_err are valid.
- out_ready  input  1: sink consumes the word this cycle.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_zero=0, out_err=0, in_ready=1, skid entry empty with contents 0. Reset overrides any simultaneous handshake.
- A reset asserted mid-stream discards both held words; nothing is emitted afterwards until a new accept.
- Accept: in_valid && in_ready at a rising edge. Consume: out_valid && out_ready at a rising edge.
- Captured word on accept:
  - sel < NUM_IN: data = channel sel, err = 0.
  - sel ≥ NUM_IN: data = 0, err = 1.
  - zero = (data == 0), including the error case.
- in_ready is registered: in_ready = !skid_valid. It never depends combinationally on out_ready.
- State machine, encoded by (out_valid, skid_valid):
  - EMPTY (0,0):
    - accept → ONE, word loaded into the output register.
  - ONE (1,0):
    - accept without consume → FULL, new word goes into the skid register and in_ready drops next cycle.
    - accept with consume → ONE, new word replaces the output register.
    - consume without accept → EMPTY.
    - neither → hold.
  - FULL (1,1): in_ready=0, so no accept is possible.
    - consume → ONE, skid word moves to the output register and in_ready returns to 1.
    - no consume → hold.
- Latency: 1 cycle from accept to out_valid when the block is EMPTY or consuming in the same cycle.
- Throughput: 1 word/cycle while out_ready=1.
- Ordering: strictly FIFO across the two entries. No word is dropped or duplicated.
- Output stability: while out_valid=1 and out_ready=0, out_data/out_zero/out_err are held constant.
- Inputs are ignored when in_valid=0. sel and in_data are don't-care in that case.

Test Plan:
- Reset, then NUM_IN=4, WIDTH=24, out_ready=1, ch0=64, ch1=256; send sel=0, then sel=1 on consecutive cycles:
  - out_data=64 one cycle after the first accept, then 256 the next cycle.
  - out_valid stays high for 2 cycles; out_zero=0, out_err=0.
- Stall: out_ready=0; accept sel=0 (64) then sel=1 (256):
  - Block reaches FULL and in_ready=0 on the cycle after the second accept.
  - Holding in_valid=1 with sel=2 (ch2=7) is not accepted.
  - Raise out_ready → outputs are 64, 256, 7 in order; in_ready returns to 1 after the first consume.
- Out-of-range sel, with NUM_IN=3, SEL_W=2: sel=3, ch values nonzero → out_data=0, out_err=1, out_zero=1.
- Zero detect: ch1=0, sel=1 → out_data=0, out_zero=1, out_err=0.
- Reset mid-operation: from FULL (64 in the output register, 256 in skid), assert rst for 1 cycle with out_ready=1:
  - Next cycle out_valid=0, out_data=0, in_ready=1; neither word is ever emitted.
- Width/param sweep: WIDTH=32, NUM_IN=8, SEL_W=3, random valid/ready for 1000 cycles.
  - A scoreboard compares the output stream to an accepted-word model; no loss, no reorder.
  - out_data is stable whenever out_valid && !out_ready.
